// File: rtl/dmem_bus_if.sv
// rtl/dmem_bus_if.sv - CPU data-port and console bus bundle for dmem_bus
interface dmem_bus_if #(
  parameter int XLEN = 32
);
  logic                mem_r;
  logic [XLEN/8-1:0]   mem_w;
  logic [XLEN-1:0]     mem_addr;
  logic [XLEN-1:0]     mem_din;
  logic [XLEN-1:0]     mem_dout;
  logic                con_valid;
  logic [7:0]          con_data;
  logic                con_ready;
  logic                halt;
  logic [7:0]          halt_code;

  modport master (
    output mem_r, mem_w, mem_addr, mem_din, con_ready,
    input  mem_dout, con_valid, con_data, halt, halt_code
  );

  modport slave (
    input  mem_r, mem_w, mem_addr, mem_din, con_ready,
    output mem_dout, con_valid, con_data, halt, halt_code
  );
endinterface

// File: rtl/dmem_bus.sv
// rtl/dmem_bus.sv - byte-addressed data RAM plus console/status/cycle/halt MMIO window
module dmem_bus #(
  parameter int              XLEN       = 32,
  parameter int              RAM_BYTES  = 4096,
  parameter int              FIFO_DEPTH = 8,
  parameter logic [XLEN-1:0] MMIO_BASE  = 'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  dmem_bus_if.slave  bus
);
  localparam int NB = XLEN / 8;
  localparam int RA = $clog2(RAM_BYTES);
  localparam int FA = $clog2(FIFO_DEPTH);
  localparam int CW = FA + 1;
  localparam logic [XLEN-1:0] RAM_LIMIT = XLEN'(RAM_BYTES);
  localparam logic [XLEN-1:0] MMIO_END  = MMIO_BASE + XLEN'(16);

  // Storage
  logic [7:0]      ram_q  [RAM_BYTES];
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [FA-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            halt_q, halt_d;
  logic [7:0]      code_q, code_d;
  logic [XLEN-1:0] cycle_q, cycle_d;

  // Decode
  logic          ram_hit, mmio_hit, mmio_sel, wr0;
  logic [3:0]    mmio_off;
  logic          push, pop, push_ok, full, empty;
  logic          status_wr, halt_wr;
  logic [RA-1:0] lane_idx [NB];
  logic [XLEN-1:0] dout_d;

  assign ram_hit   = bus.mem_addr < RAM_LIMIT;
  assign mmio_hit  = (bus.mem_addr >= MMIO_BASE) && (bus.mem_addr < MMIO_END);
  assign mmio_sel  = mmio_hit && (bus.mem_addr[1:0] == 2'b00);
  assign mmio_off  = 4'(bus.mem_addr - MMIO_BASE);
  assign wr0       = mmio_sel && bus.mem_w[0];
  assign push      = wr0 && (mmio_off[3:2] == 2'd0);
  assign status_wr = wr0 && (mmio_off[3:2] == 2'd1);
  assign halt_wr   = wr0 && (mmio_off[3:2] == 2'd3);

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = !empty && bus.con_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);

  assign bus.con_valid = !empty;
  assign bus.con_data  = fifo_q[rd_q];
  assign bus.halt      = halt_q;
  assign bus.halt_code = code_q;
  assign bus.mem_dout  = dout_d;

  // Per-lane RAM byte index, wrapping around the top of RAM
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      lane_idx[i] = bus.mem_addr[RA-1:0] + RA'(i);
    end
  end

  // Combinational read mux; zero for idle, unmapped and misaligned MMIO reads
  always_comb begin
    dout_d = '0;
    if (bus.mem_r) begin
      if (ram_hit) begin
        for (int i = 0; i < NB; i++) begin
          dout_d[8*i +: 8] = ram_q[lane_idx[i]];
        end
      end else if (mmio_sel) begin
        case (mmio_off[3:2])
          2'd1:    dout_d = XLEN'({8'(count_q), 5'b0, ovf_q, empty, full});
          2'd2:    dout_d = cycle_q;
          2'd3:    dout_d = XLEN'({code_q, 7'b0, halt_q});
          default: dout_d = '0;
        endcase
      end
    end
  end

  // RAM byte writes; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (ram_hit && bus.mem_w[i]) begin
        ram_q[lane_idx[i]] <= bus.mem_din[8*i +: 8];
      end
    end
  end

  // FIFO data slots; a push during reset is dropped
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      fifo_q[wr_q] <= bus.mem_din[7:0];
    end
  end

  // Next-state for FIFO control, overflow flag, halt and cycle counter
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    halt_d  = halt_q;
    code_d  = code_q;
    cycle_d = cycle_q + XLEN'(1);
    if (pop)     rd_d = rd_q + FA'(1);
    if (push_ok) wr_d = wr_q + FA'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop);
    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end else if (status_wr && bus.mem_din[2]) begin
      ovf_d = 1'b0;
    end
    if (halt_wr && !halt_q) begin
      halt_d = 1'b1;
      code_d = bus.mem_din[7:0];
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      halt_q  <= 1'b0;
      code_q  <= '0;
      cycle_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      halt_q  <= halt_d;
      code_q  <= code_d;
      cycle_q <= cycle_d;
    end
  end
endmodule

// File: tb/tb_dmem_bus.sv
// tb/tb_dmem_bus.sv - directed and randomized checks of dmem_bus against a behavioural model
module tb_dmem_bus;
  localparam int          XLEN      = 32;
  localparam int          NB        = XLEN / 8;
  localparam int          RAM_BYTES = 4096;
  localparam int          DEPTH     = 8;
  localparam logic [31:0] BASE      = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset;

  dmem_bus_if #(.XLEN(XLEN)) bus ();

  dmem_bus #(
    .XLEN(XLEN), .RAM_BYTES(RAM_BYTES), .FIFO_DEPTH(DEPTH), .MMIO_BASE(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0]   mram  [RAM_BYTES];
  bit           known [RAM_BYTES];
  byte unsigned mq[$];
  bit           m_ovf, m_halt, m_valid;
  logic [7:0]   m_code;
  logic [31:0]  m_cyc;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit in_mmio(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd16) && (a[1:0] == 2'b00);
  endfunction

  task automatic exp_read(output logic [31:0] e, output logic [31:0] m);
    longint unsigned a;
    int sz;
    e = '0;
    m = '1;
    a = longint'(bus.mem_addr);
    sz = mq.size();
    if (bus.mem_r) begin
      if (a < RAM_BYTES) begin
        for (int i = 0; i < NB; i++) begin
          int idx;
          idx = int'((a + longint'(i)) % RAM_BYTES);
          if (known[idx]) e[8*i +: 8] = mram[idx];
          else            m[8*i +: 8] = 8'h00;
        end
      end else if (in_mmio(bus.mem_addr)) begin
        case ((a - longint'(BASE)) / 4)
          1: e = (sz * 256) + (m_ovf ? 4 : 0) + (sz == 0 ? 2 : 0) + (sz == DEPTH ? 1 : 0);
          2: e = m_cyc;
          3: e = {16'h0, m_code, 7'b0, m_halt};
          default: e = '0;
        endcase
      end
    end
  endtask

  task automatic compare_model();
    logic [31:0] e, m;
    if (!m_valid) return;
    exp_read(e, m);
    chk("dout", bus.mem_dout & m, e & m);
    chk("con_valid", bus.con_valid, mq.size() != 0);
    if (mq.size() != 0) chk("con_data", bus.con_data, mq[0]);
    chk("halt", bus.halt, m_halt);
    chk("halt_code", bus.halt_code, m_code);
  endtask

  task automatic model_update();
    logic [31:0] a;
    int sz, off;
    bit pop, w0, sel;
    a = bus.mem_addr;
    if (longint'(a) < RAM_BYTES) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.mem_w[i]) begin
          int idx;
          idx = int'((longint'(a) + longint'(i)) % RAM_BYTES);
          mram[idx]  = bus.mem_din[8*i +: 8];
          known[idx] = 1'b1;
        end
      end
    end
    if (reset) begin
      mq.delete();
      m_ovf = 0; m_halt = 0; m_code = 8'h00; m_cyc = 32'h0;
      m_valid = 1;
      return;
    end
    if (!m_valid) return;
    m_cyc = m_cyc + 32'd1;
    sel = in_mmio(a);
    off = int'((a - BASE) >> 2);
    w0  = bus.mem_w[0];
    sz  = mq.size();
    pop = (sz > 0) && bus.con_ready;
    if (pop) void'(mq.pop_front());
    if (sel && w0 && off == 0) begin
      if (sz < DEPTH || pop) mq.push_back(bus.mem_din[7:0]);
      else m_ovf = 1;
    end
    if (sel && w0 && off == 1 && bus.mem_din[2]) m_ovf = 0;
    if (sel && w0 && off == 3 && !m_halt) begin
      m_halt = 1;
      m_code = bus.mem_din[7:0];
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare_model();
  endtask

  task automatic adv();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic drive(input bit r, input logic [3:0] w, input logic [31:0] addr, input logic [31:0] din);
    bus.mem_r    = r;
    bus.mem_w    = w;
    bus.mem_addr = addr;
    bus.mem_din  = din;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    m_valid = 0;
    reset = 1'b1;
    bus.con_ready = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Byte-lane RAM writes
    drive(0, 4'h1, 32'h0, 32'd132); tick();
    drive(1, 4'h0, 32'h0, 32'h0); settle(); chk("t1_byte0", bus.mem_dout[7:0], 8'd132); adv();
    drive(0, 4'h2, 32'h0, 32'd232 << 8); tick();
    drive(1, 4'h0, 32'h0, 32'h0); settle(); chk("t1_half", bus.mem_dout[15:0], 16'hE884); adv();

    // Console push and drain
    drive(0, 4'h1, BASE, 32'h48); tick();
    drive(0, 4'h1, BASE, 32'h69); tick();
    idle(); settle(); chk("t2_valid", bus.con_valid, 1'b1); chk("t2_head", bus.con_data, 8'h48); adv();
    bus.con_ready = 1'b1;
    settle(); chk("t2_pop0", bus.con_data, 8'h48); adv();
    settle(); chk("t2_pop1", bus.con_data, 8'h69); adv();
    settle(); chk("t2_empty", bus.con_valid, 1'b0); adv();
    bus.con_ready = 1'b0;

    // Overflow, ovf clear, push+pop while full
    for (int k = 0; k < 9; k++) begin
      drive(0, 4'h1, BASE, 32'(8'h30 + k)); tick();
    end
    drive(1, 4'h0, BASE + 4, 32'h0); settle(); chk("t3_ovf", bus.mem_dout, 32'h0805); adv();
    drive(0, 4'h1, BASE + 4, 32'h4); tick();
    drive(1, 4'h0, BASE + 4, 32'h0); settle(); chk("t3_clr", bus.mem_dout, 32'h0801); adv();
    bus.con_ready = 1'b1;
    drive(0, 4'h1, BASE, 32'h55); tick();
    bus.con_ready = 1'b0;
    drive(1, 4'h0, BASE + 4, 32'h0); settle(); chk("t3_pushpop", bus.mem_dout, 32'h0801); adv();

    // Cycle counter after reset release
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    drive(1, 4'h0, BASE + 8, 32'h0); settle(); chk("t4_cyc0", bus.mem_dout, 32'd0); adv();
    repeat (9) tick();
    settle(); chk("t4_cyc10", bus.mem_dout, 32'd10); adv();
    drive(0, 4'hF, BASE + 8, 32'h1234); tick();
    drive(1, 4'h0, BASE + 8, 32'h0); settle(); chk("t4_cycwr", bus.mem_dout, 32'd12); adv();

    // Halt register
    drive(0, 4'h1, BASE + 12, 32'h2A); tick();
    idle(); settle(); chk("t5_halt", bus.halt, 1'b1); chk("t5_code", bus.halt_code, 8'h2A); adv();
    drive(0, 4'h1, BASE + 12, 32'h01); tick();
    drive(0, 4'h1, BASE + 13, 32'h07); tick();
    drive(1, 4'h0, BASE + 12, 32'h0); settle();
    chk("t5_code_kept", bus.halt_code, 8'h2A); chk("t5_read", bus.mem_dout, 32'h2A01); adv();

    // Reset with queued bytes and ovf set
    for (int k = 0; k < 9; k++) begin
      drive(0, 4'h1, BASE, 32'(8'h61 + k)); tick();
    end
    idle(); bus.con_ready = 1'b1;
    repeat (5) tick();
    bus.con_ready = 1'b0;
    drive(1, 4'h0, BASE + 4, 32'h0); settle(); chk("t6_pre", bus.mem_dout, 32'h0304); adv();
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    drive(1, 4'h0, BASE + 8, 32'h0); settle();
    chk("t6_valid", bus.con_valid, 1'b0); chk("t6_cyc", bus.mem_dout, 32'd0); chk("t6_halt", bus.halt, 1'b0); adv();
    drive(1, 4'h0, BASE + 4, 32'h0); settle(); chk("t6_status", bus.mem_dout, 32'h0002); adv();
    drive(1, 4'h0, 32'h0, 32'h0); settle(); chk("t6_ram", bus.mem_dout[7:0], 8'd132); adv();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: ra = 32'($urandom_range(0, 31));
        3:       ra = 32'(RAM_BYTES - $urandom_range(1, 3));
        4, 5, 6: ra = BASE + 32'(4 * $urandom_range(0, 3));
        7:       ra = BASE + 32'($urandom_range(0, 15));
        8: begin
          case ($urandom_range(0, 3))
            0:       ra = 32'(RAM_BYTES);
            1:       ra = BASE - 32'd4;
            2:       ra = BASE + 32'd16;
            default: ra = 32'hFFFF_FFFC;
          endcase
        end
        default: ra = 32'($urandom_range(0, RAM_BYTES - 1));
      endcase
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
            ra, $urandom());
      bus.con_ready = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
